// File: rtl/ex_pkg.sv
// Shared encodings for the EX stage: ALU operations, mul/div operations,
// default mul/div latencies and the mul/div unit state encoding.
package ex_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_ctrl_e;

  typedef enum logic [3:0] {
    MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
    MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO
  } md_op_e;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. Operands are latched
// at start; the result is computed from the latched copy and lands on the last busy edge.
module muldiv_unit
  import ex_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  md_state_e        state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;

  logic               is_signed, a_neg, b_neg;
  logic [2*WIDTH-1:0] mul_a, mul_b, prod;
  logic [WIDTH-1:0]   mag_a, mag_b, q_mag, r_mag, quo, rem;

  // Signed ops sign-extend into a 2*WIDTH product; divide works on magnitudes
  // so most-negative / -1 wraps back to most-negative with a zero remainder.
  always_comb begin
    is_signed = (op_q == MD_MULT) || (op_q == MD_DIV);
    a_neg     = is_signed & a_q[WIDTH-1];
    b_neg     = is_signed & b_q[WIDTH-1];
    mul_a     = {{WIDTH{a_neg}}, a_q};
    mul_b     = {{WIDTH{b_neg}}, b_q};
    prod      = mul_a * mul_b;
    mag_a     = a_neg ? -a_q : a_q;
    mag_b     = b_neg ? -b_q : b_q;
    q_mag     = (mag_b != '0) ? mag_a / mag_b : '0;
    r_mag     = (mag_b != '0) ? mag_a % mag_b : '0;
    quo       = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem       = a_neg ? -r_mag : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          op_d    = op;
          a_d     = a;
          b_d     = b;
          cnt_d   = ((op == MD_DIV) || (op == MD_DIVU)) ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
        end else begin
          if (mthi_we) hi_d = wdata;
          if (mtlo_we) lo_d = wdata;
        end
      end
      default: begin
        cnt_d = cnt_q - 32'd1;
        if (cnt_q == 32'd1) begin
          state_d = MD_IDLE;
          if ((op_q == MD_MULT) || (op_q == MD_MULTU)) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (b_q != '0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/ex_muldiv_stage.sv
// EX stage: ALU, B-operand mux and result mux, plus an optional HI/LO mul/div
// unit enabled by defining EX_MULDIV_EN (without it busy/stall are 0, MFHI/MFLO read 0).
module ex_muldiv_stage
  import ex_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] pc,
  input  logic [3:0]       alu_ctrl,
  input  logic             alu_src,
  input  logic             link_en,
  input  logic [3:0]       md_op,
  input  logic             issue,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             stall
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] b_op, alu_out, hi_v, lo_v;
  logic [SHW-1:0]   shamt;

  assign b_op  = alu_src ? imm : rt_val;
  assign shamt = b_op[SHW-1:0];

  always_comb begin
    alu_out = '0;
    case (alu_ctrl)
      ALU_ADD:  alu_out = rs_val + b_op;
      ALU_SUB:  alu_out = rs_val - b_op;
      ALU_AND:  alu_out = rs_val & b_op;
      ALU_OR:   alu_out = rs_val | b_op;
      ALU_XOR:  alu_out = rs_val ^ b_op;
      ALU_NOR:  alu_out = ~(rs_val | b_op);
      ALU_SLT:  alu_out = WIDTH'($signed(rs_val) < $signed(b_op));
      ALU_SLTU: alu_out = WIDTH'(rs_val < b_op);
      ALU_SLL:  alu_out = rs_val << shamt;
      ALU_SRL:  alu_out = rs_val >> shamt;
      ALU_SRA:  alu_out = WIDTH'($signed(rs_val) >>> shamt);
      ALU_LUI:  alu_out = b_op << 16;
      default:  alu_out = '0;
    endcase
  end

`ifdef EX_MULDIV_EN
  logic md_start, md_is_muldiv, md_ok;

  // Nothing is accepted while busy; stall holds ID/EX until the unit frees up.
  assign md_is_muldiv = (md_op == MD_MULT) || (md_op == MD_MULTU) ||
                        (md_op == MD_DIV)  || (md_op == MD_DIVU);
  assign md_ok        = issue & ~flush & ~busy;
  assign md_start     = md_ok & md_is_muldiv;
  assign stall        = issue & (md_op != MD_NONE) & busy;

  muldiv_unit #(
    .WIDTH      (WIDTH),
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .op     (md_op),
    .a      (rs_val),
    .b      (rt_val),
    .mthi_we(md_ok & (md_op == MD_MTHI)),
    .mtlo_we(md_ok & (md_op == MD_MTLO)),
    .wdata  (rs_val),
    .hi     (hi_v),
    .lo     (lo_v),
    .busy   (busy)
  );
`else
  wire unused_md = &{1'b0, clk, reset, issue, flush};
  assign hi_v  = '0;
  assign lo_v  = '0;
  assign busy  = 1'b0;
  assign stall = 1'b0;
`endif

  always_comb begin
    result = alu_out;
    if (link_en)                result = pc + WIDTH'(8);
    else if (md_op == MD_MFHI)  result = hi_v;
    else if (md_op == MD_MFLO)  result = lo_v;
  end

  assign zero = (alu_out == '0);

endmodule

// File: doc/ex_muldiv_stage.md
EX_MULDIV_STAGE -- requirements
Module: ex_muldiv_stage

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits.
REQ-002 Parameter MULT_CYCLES, default 5, multiply latency in cycles (>=1).
REQ-003 Parameter DIV_CYCLES, default 10, divide latency in cycles (>=1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 rs_val, rt_val, imm, pc  input  WIDTH each  forwarded operands, extended immediate, instruction PC.
REQ-007 alu_ctrl  input  4  ALU operation code (package enum).
REQ-008 alu_src  input  1  1 selects imm as ALU B operand, 0 selects rt_val.
REQ-009 link_en  input  1  result is pc+8 (jal/jalr).
REQ-010 md_op  input  4  NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
REQ-011 issue  input  1  valid instruction present in EX this cycle.
REQ-012 flush  input  1  kill the EX-stage instruction this cycle.
REQ-013 result  output  WIDTH  EX result to EX/MEM register.
REQ-014 zero  output  1  ALU result equals zero.
REQ-015 busy  output  1  mul/div operation in progress.
REQ-016 stall  output  1  hold ID/EX; issue is an md_op (any but NONE) while busy.

Function
REQ-017 result priority: link_en -> pc+8; MFHI -> HI; MFLO -> LO; else ALU output; combinational.
REQ-018 ALU supports add, sub, and, or, xor, nor, slt, sltu, sll, srl, sra, lui; shifts use low log2(WIDTH) bits of B.
REQ-019 FSM states IDLE, BUSY; 32-bit-max down-counter cnt.
REQ-020 IDLE -> BUSY when issue & !flush & md_op in {MULT,MULTU,DIV,DIVU}; operands latched; cnt loaded with MULT_CYCLES or DIV_CYCLES.
REQ-021 BUSY: cnt decrements each cycle; at cnt==1, HI/LO written on that edge, state -> IDLE, busy low the following cycle.
REQ-022 busy is high exactly MULT_CYCLES (or DIV_CYCLES) cycles beginning the cycle after issue.
REQ-023 MULT/MULTU: {HI,LO} = signed/unsigned 2*WIDTH product.
REQ-024 DIV/DIVU: LO = quotient (truncate toward zero), HI = remainder (sign of dividend).
REQ-025 Divide by zero: operation runs full latency, HI/LO unchanged.
REQ-026 Signed DIV of most-negative by -1: LO = most-negative, HI = 0.
REQ-027 MTHI/MTLO with issue & !flush & !busy write rs_val to HI/LO on the next edge; zero latency to subsequent MFHI/MFLO.
REQ-028 Any md_op issued while busy is not accepted; stall held until busy low, then accepted.
REQ-029 flush suppresses start and MTHI/MTLO writes in that cycle; flush during BUSY does not cancel the running operation.
REQ-030 MFHI/MFLO while busy: stall asserted; result is the final value once released.

Reset
REQ-031 reset low at clk edge: state IDLE, cnt 0, HI 0, LO 0, busy 0, stall 0.
REQ-032 reset mid-operation aborts it; HI/LO read 0 afterward.
REQ-033 result and zero are combinational and carry no reset value.

Configuration
REQ-034 Macro EX_MULDIV_EN: defined -> mul/div unit, HI/LO, busy, stall as specified.
REQ-035 Undefined -> no HI/LO storage; busy and stall tied 0; MFHI/MFLO return 0; other md_ops are no-ops.

Structure
REQ-036 Package ex_pkg: alu_ctrl enum, md_op enum, default MULT_CYCLES/DIV_CYCLES constants.
REQ-037 Sub-module muldiv_unit holds FSM, counter, HI/LO; top holds ALU, B-mux, result mux.

Verification
REQ-038 alu_ctrl=add, rs=5, imm=7, alu_src=1 -> result 12, zero 0; sub 5-5 -> zero 1.
REQ-039 MULT rs=-3, rt=4 -> busy 5 cycles, then MFLO 0xFFFFFFF4, MFHI 0xFFFFFFFF.
REQ-040 DIVU rs=17, rt=5; MFLO issued next cycle -> stall 10 cycles, then result 3; MFHI -> 2.
REQ-041 DIV rs=0x80000000, rt=0xFFFFFFFF -> LO 0x80000000, HI 0; DIV by 0 -> HI/LO unchanged.
REQ-042 MULT issued with flush=1 -> busy stays 0; reset low at cycle 3 of a DIV -> busy 0, HI=LO=0.
REQ-043 link_en=1, pc=0x3000 -> result 0x3008 regardless of ALU inputs.
